// File: rtl/hazard_ctrl.sv
// Load-use / branch hazard controller driving the ID/EX bubble, PC and IF/ID hold/flush.
// Define HAZARD_STATS_EN to build the saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [5:0]  LW_OP        = 6'b100011,
  parameter int          CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_dest,
  input  logic [5:0]       ex_op,
  input  logic             branch_taken,
  output logic             stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic       lu;

  assign lu = (ex_op == LW_OP) && (ex_dest != 5'd0) &&
              ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

  assign state_o = state;

  // Controls are decoded from the current state and live inputs so the
  // bubble lands in the same cycle the hazard is seen.
  always_comb begin
    stall      = 1'b0;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            stall      = 1'b1;
            ifid_flush = 1'b1;
          end else if (lu) begin
            stall     = 1'b1;
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
          end
        end
        FLUSH: begin
          stall      = 1'b1;
          ifid_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            flush_cnt <= FLUSH_LOAD;
            state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (lu) begin
            state <= LU_STALL;
          end
        end
        // The bubble now occupies EX, so neither lu nor a branch can fire here.
        LU_STALL: state <= RUN;
        FLUSH: begin
          flush_cnt <= flush_cnt - 4'd1;
          if (flush_cnt <= 4'd1) state <= RUN;
        end
        default: begin
          state     <= RUN;
          flush_cnt <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state == RUN) begin
      if (branch_taken) begin
        if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
      end else if (lu) begin
        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
